// File: rtl/vpu_requant_channel_if.sv
// vpu_requant_channel_if: input-vector and output-row streams of the requant channel.
// slave is the channel side, master is the producer/consumer side.
interface vpu_requant_channel_if #(
    parameter int CHANNEL_WIDTH = 16,
    parameter int I_WIDTH       = 32,
    parameter int O_WIDTH       = 8,
    parameter int DEPTH         = 16
);
    logic                                    in_valid;
    logic                                    in_ready;
    logic [CHANNEL_WIDTH-1:0][I_WIDTH-1:0]   in_data;
    logic                                    out_valid;
    logic                                    out_ready;
    logic [CHANNEL_WIDTH-1:0][O_WIDTH-1:0]   out_data;
    logic [$clog2(DEPTH)-1:0]                out_row;

    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_row);
    modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_row);
endinterface

// File: rtl/vpu_requant_channel.sv
// vpu_requant_channel: multi-pass per-lane psum accumulation, then bias/ReLU/scale/round/saturate drain.
// Define VPU_SAT_COUNT_EN to add a sticky count of saturated lanes on sat_count.
module vpu_requant_channel #(
    parameter int CHANNEL_WIDTH = 16,
    parameter int I_WIDTH       = 32,
    parameter int ACC_WIDTH     = 32,
    parameter int O_WIDTH       = 8,
    parameter int DEPTH         = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [$clog2(DEPTH):0]                num_rows,
    input  logic [7:0]                            num_passes,
    input  logic [15:0]                           scale,
    input  logic [4:0]                            shift,
    input  logic                                  relu_en,
    input  logic [CHANNEL_WIDTH-1:0][ACC_WIDTH-1:0] bias_in,
    vpu_requant_channel_if.slave                  bus,
    output logic                                  busy,
    output logic                                  done,
    output logic [15:0]                           sat_count
);
    localparam int RW = $clog2(DEPTH);
    localparam int SW = ACC_WIDTH + 1;
    localparam int PW = ACC_WIDTH + 18;
    localparam logic signed [PW-1:0] SMAX = PW'(2 ** (O_WIDTH - 1) - 1);
    localparam logic signed [PW-1:0] SMIN = -SMAX - 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, FLUSH} state_t;

    state_t                  state;
    logic [RW:0]             rows_q;
    logic [7:0]              passes_q, pass_cnt;
    logic [15:0]             scale_q;
    logic [4:0]              shift_q;
    logic                    relu_q;
    logic [RW-1:0]           row_ptr, iss_row, last_row;
    logic signed [ACC_WIDTH-1:0] psum [DEPTH][CHANNEL_WIDTH];
    logic                    s1_valid;
    logic [RW-1:0]           s1_row;
    logic signed [SW-1:0]    s1_sum [CHANNEL_WIDTH];
    logic signed [SW-1:0]    s1_rl [CHANNEL_WIDTH];
    logic signed [PW-1:0]    s1_next [CHANNEL_WIDTH];
    logic signed [PW-1:0]    s1_prod [CHANNEL_WIDTH];
    logic signed [PW-1:0]    s2_shr [CHANNEL_WIDTH];
    logic signed [PW-1:0]    rnd;
    logic                    adv;

    assign last_row     = RW'(rows_q - 1'b1);
    // The whole pipeline advances together; only a held output row can stall it.
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = state == ACCUM;
    assign busy         = state != IDLE;
    assign rnd          = shift_q == 5'd0 ? '0 : PW'(1) << (shift_q - 5'd1);

    always_comb begin
        for (int i = 0; i < CHANNEL_WIDTH; i++) begin
            s1_sum[i]  = SW'(psum[iss_row][i]) + SW'(signed'(bias_in[i]));
            s1_rl[i]   = (relu_q && s1_sum[i][SW-1]) ? '0 : s1_sum[i];
            s1_next[i] = PW'(s1_rl[i]) * PW'(signed'({1'b0, scale_q}));
            s2_shr[i]  = (s1_prod[i] + rnd) >>> shift_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            rows_q        <= '0;
            passes_q      <= '0;
            scale_q       <= '0;
            shift_q       <= '0;
            relu_q        <= 1'b0;
            row_ptr       <= '0;
            iss_row       <= '0;
            pass_cnt      <= '0;
            done          <= 1'b0;
            s1_valid      <= 1'b0;
            s1_row        <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_row   <= '0;
            for (int i = 0; i < CHANNEL_WIDTH; i++) begin
                s1_prod[i] <= '0;
                for (int d = 0; d < DEPTH; d++)
                    psum[d][i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    rows_q   <= num_rows == '0 ? (RW+1)'(DEPTH) : num_rows;
                    passes_q <= num_passes == 8'd0 ? 8'd1 : num_passes;
                    scale_q  <= scale;
                    shift_q  <= shift;
                    relu_q   <= relu_en;
                    row_ptr  <= '0;
                    iss_row  <= '0;
                    pass_cnt <= '0;
                    state    <= ACCUM;
                end
                ACCUM: if (bus.in_valid) begin
                    for (int i = 0; i < CHANNEL_WIDTH; i++)
                        psum[row_ptr][i] <= psum[row_ptr][i] + ACC_WIDTH'(signed'(bus.in_data[i]));
                    row_ptr <= row_ptr == last_row ? '0 : row_ptr + 1'b1;
                    if (row_ptr == last_row) begin
                        pass_cnt <= pass_cnt + 8'd1;
                        if (pass_cnt + 8'd1 == passes_q) begin
                            pass_cnt <= '0;
                            state    <= DRAIN;
                        end
                    end
                end
                // Issued rows are zeroed so the next job starts from clean accumulators.
                DRAIN: if (adv) begin
                    for (int i = 0; i < CHANNEL_WIDTH; i++)
                        psum[iss_row][i] <= '0;
                    iss_row <= iss_row == last_row ? '0 : iss_row + 1'b1;
                    if (iss_row == last_row)
                        state <= FLUSH;
                end
                FLUSH: if (bus.out_valid && bus.out_ready && bus.out_row == last_row) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
            if (adv) begin
                s1_valid      <= state == DRAIN;
                s1_row        <= iss_row;
                s1_prod       <= s1_next;
                bus.out_valid <= s1_valid;
                if (s1_valid) begin
                    bus.out_row <= s1_row;
                    for (int i = 0; i < CHANNEL_WIDTH; i++)
                        bus.out_data[i] <= s2_shr[i] > SMAX ? SMAX[O_WIDTH-1:0] :
                                           s2_shr[i] < SMIN ? SMIN[O_WIDTH-1:0] : s2_shr[i][O_WIDTH-1:0];
                end
            end
        end
    end

`ifdef VPU_SAT_COUNT_EN
    logic [CHANNEL_WIDTH-1:0] s2_sat, out_sat;
    logic [16:0]              sat_sum;

    always_comb begin
        sat_sum = {1'b0, sat_count};
        for (int i = 0; i < CHANNEL_WIDTH; i++) begin
            s2_sat[i] = s2_shr[i] > SMAX || s2_shr[i] < SMIN;
            sat_sum   = sat_sum + 17'(out_sat[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_count <= '0;
            out_sat   <= '0;
        end else begin
            if (adv && s1_valid)
                out_sat <= s2_sat;
            if (state == IDLE && start)
                sat_count <= '0;
            else if (bus.out_valid && bus.out_ready)
                sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
        end
    end
`else
    assign sat_count = '0;
`endif
endmodule

// File: tb/tb_vpu_requant_channel.sv
// tb_vpu_requant_channel: scoreboard bench; expected rows are queued as each job is fed
// and compared as the channel transfers them.
module tb_vpu_requant_channel;
    localparam int CW = 4;
    localparam int IW = 32;
    localparam int AW = 32;
    localparam int OW = 8;
    localparam int D  = 16;
    localparam int RW = 4;

    typedef struct packed {
        logic [RW-1:0] row;
        logic [31:0]   data;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  start = 1'b0;
    logic                  relu_en = 1'b0;
    logic [RW:0]           num_rows = '0;
    logic [7:0]            num_passes = '0;
    logic [15:0]           scale = '0;
    logic [4:0]            shift = '0;
    logic [CW-1:0][AW-1:0] bias_in = '0;
    logic                  busy, done;
    logic [15:0]           sat_count;

    int   n_checks = 0;
    int   n_errors = 0;
    int   rdy_mode = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];

    vpu_requant_channel_if #(.CHANNEL_WIDTH(CW), .I_WIDTH(IW), .O_WIDTH(OW), .DEPTH(D)) bus();

    vpu_requant_channel #(
        .CHANNEL_WIDTH(CW), .I_WIDTH(IW), .ACC_WIDTH(AW), .O_WIDTH(OW), .DEPTH(D)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_rows(num_rows), .num_passes(num_passes),
        .scale(scale), .shift(shift), .relu_en(relu_en), .bias_in(bias_in), .bus(bus),
        .busy(busy), .done(done), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rq(input int acc, input int bias, input int sc, input int sh,
                                      input bit relu, output bit sat);
        longint v;
        v = longint'(acc) + longint'(bias);
        if (relu && v < 0) v = 0;
        v = v * sc;
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
        v = v >>> sh;
        sat = (v > 127) || (v < -128);
        if (v > 127) v = 127;
        else if (v < -128) v = -128;
        return v[7:0];
    endfunction

    // out_ready: 0 = always ready, 1 = random backpressure, 2 = held low
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 2 ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        logic        pv, pr;
        logic [31:0] pd;
        logic [RW-1:0] prow;
        exp_t        e;
        pv = 1'b0; pr = 1'b0; pd = '0; prow = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pv = 1'b0;
            end else begin
                if (pv && !pr) begin
                    check("hold_data", bus.out_data, pd);
                    check("hold_row", bus.out_row, prow);
                end
                if (done) done_cnt++;
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_row", bus.out_row, e.row);
                        check("out_data", bus.out_data, e.data);
                    end
                end
                pv = bus.out_valid; pr = bus.out_ready; pd = bus.out_data; prow = bus.out_row;
            end
        end
    end

    task automatic rst_checks();
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_row", bus.out_row, 0);
        check("rst_sat_count", sat_count, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1 rst_checks();
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                step();
                return;
            end
        end
        check("in_ready_timeout", 0, 1);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk);
            seen = done;
        end
        check("done_seen", seen, 1);
    endtask

    // abort: 0 = full job, 1 = reset after 3 beats of ACCUM, 2 = reset during DRAIN
    task automatic run_job(input int rows, input int passes, input int sc, input int sh, input bit relu,
                           input int val, input bit rnd, input int bias_v, input int rdy,
                           input bit stall, input int abort);
        int nr, np, d, sat_exp, beats;
        int ps[D][CW];
        int bs[CW];
        logic [31:0] pk;
        bit s;
        nr = rows == 0 ? D : rows;
        np = passes == 0 ? 1 : passes;
        sat_exp = 0; beats = 0; done_cnt = 0; pk = '0;
        rdy_mode = rdy;
        for (int l = 0; l < CW; l++) begin
            bs[l] = rnd ? bias_v + l * 37 - 50 : bias_v;
            bias_in[l] = bs[l];
            for (int r = 0; r < D; r++) ps[r][l] = 0;
        end
        num_rows = 5'(rows); num_passes = 8'(passes); scale = 16'(sc); shift = 5'(sh); relu_en = relu;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int p = 0; p < np; p++) begin
            for (int r = 0; r < nr; r++) begin
                if (rnd && $urandom_range(0, 3) == 0) begin
                    bus.in_valid = 1'b0;
                    step();
                end
                for (int l = 0; l < CW; l++) begin
                    d = rnd ? int'($urandom_range(0, 2 * val)) - val : val;
                    bus.in_data[l] = d;
                    ps[r][l] += d;
                end
                bus.in_valid = 1'b1;
                wait_ready();
                beats++;
                if (abort == 1 && beats == 3) begin
                    bus.in_valid = 1'b0;
                    do_reset();
                    return;
                end
            end
        end
        bus.in_valid = 1'b0;
        for (int r = 0; r < nr; r++) begin
            for (int l = 0; l < CW; l++) begin
                pk[l*8 +: 8] = rq(ps[r][l], bs[l], sc, sh, relu, s);
                sat_exp += int'(s);
            end
            exp_q.push_back('{row: RW'(r), data: pk});
        end
        if (abort == 2) begin
            rdy_mode = 2;
            repeat (4) step();
            exp_q.delete();
            do_reset();
            rdy_mode = rdy;
            return;
        end
        if (stall) begin
            rdy_mode = 2;
            repeat (2) step();
            num_rows = 5'd1; num_passes = 8'd7; scale = 16'd99; shift = 5'd3;
            start = 1'b1;
            step();
            start = 1'b0;
            repeat (5) step();
            check("busy_after_ignored_start", busy, 1);
            rdy_mode = rdy;
        end
        wait_done();
        check("queue_drained", exp_q.size(), 0);
        step();
        step();
        check("done_once", done_cnt, 1);
        check("idle_not_busy", busy, 0);
`ifdef VPU_SAT_COUNT_EN
        check("sat_count", sat_count, sat_exp > 65535 ? 65535 : sat_exp);
`else
        check("sat_count", sat_count, 0);
`endif
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "simulation timeout");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (2) step();
        rst_checks();
        rst = 1'b1;
        step();
        run_job(2, 3, 1, 0, 0, 10, 0, 0, 0, 0, 0);
        run_job(1, 1, 1, 0, 1, 100, 0, -300, 0, 0, 0);
        run_job(1, 1, 1, 0, 0, 100, 0, -300, 0, 0, 0);
        run_job(1, 1, 3, 2, 0, 5, 0, 0, 0, 0, 0);
        run_job(1, 1, 1, 2, 0, 6, 0, 0, 0, 0, 0);
        run_job(4, 2, 1, 0, 0, 20, 1, 5, 0, 1, 0);
        run_job(0, 0, 700, 12, 0, 100000, 1, 300, 1, 0, 0);
        for (int j = 0; j < 4; j++)
            run_job($urandom_range(0, D), $urandom_range(0, 3), $urandom_range(0, 2000),
                    $urandom_range(0, 20), 1'($urandom_range(0, 1)), 100000, 1,
                    int'($urandom_range(0, 2000)) - 1000, 1, 0, 0);
        run_job(4, 2, 1, 0, 0, 50, 0, 0, 0, 0, 1);
        run_job(4, 1, 2, 1, 0, 1000, 1, 10, 1, 0, 0);
        run_job(4, 1, 1, 0, 0, 40, 1, 0, 0, 0, 2);
        run_job(3, 2, 1, 1, 1, 60, 1, -20, 1, 0, 0);
        repeat (5) step();
        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
